// File: rtl/dmem_mux_pkg.sv
// dmem_mux_pkg: shared state encoding and default data width for the write-back select stage
package dmem_mux_pkg;
  localparam int DMEM_DATA_W = 8;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;
endpackage

// File: rtl/mux_nto1.sv
// mux_nto1: combinational N:1 binary-select mux; an out-of-range select yields source 0
module mux_nto1 import dmem_mux_pkg::*; #(
  parameter int WIDTH  = DMEM_DATA_W,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o
);
  always_comb begin
    data_o = data_i[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++)
      if (32'(sel_i) == k) data_o = data_i[k*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/dmem_wb_select_stage.sv
// dmem_wb_select_stage: registered N-way select with valid/ready and a one-entry skid buffer.
// Define DMEM_MUX_SELCHK_EN to flag out-of-range selects on sel_err and zero their data.
module dmem_wb_select_stage import dmem_mux_pkg::*; #(
  parameter int WIDTH  = DMEM_DATA_W,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);
  state_e           state_q;
  logic [WIDTH-1:0] main_q, skid_q, sel_data, mux_data;
  logic             out_valid_q, in_ready_q, accept, emit;

  mux_nto1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
    .data_i(in_data),
    .sel_i (in_sel),
    .data_o(sel_data)
  );

  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef DMEM_MUX_SELCHK_EN
  logic oor, sel_err_q;
  assign oor      = 32'(in_sel) >= NUM_IN;
  assign mux_data = oor ? '0 : sel_data;
  assign sel_err  = sel_err_q;
  always_ff @(posedge clk)
    if (rst) sel_err_q <= 1'b0;
    else if (accept & oor & ~flush) sel_err_q <= 1'b1;
`else
  assign mux_data = sel_data;
  assign sel_err  = 1'b0;
`endif

  // flush empties both entries but leaves main_q visible on out_data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          main_q      <= mux_data;
          state_q     <= ST_ONE;
          out_valid_q <= 1'b1;
        end
        ST_ONE: if (accept & emit) main_q <= mux_data;
        else if (accept) begin
          skid_q     <= mux_data;
          state_q    <= ST_TWO;
          in_ready_q <= 1'b0;
        end else if (emit) begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
        ST_TWO: if (emit) begin
          main_q     <= skid_q;
          state_q    <= ST_ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_wb_select_stage.sv
// tb_dmem_wb_select_stage: directed vector table, sel_err sequence and random traffic against a queue model
module tb_dmem_wb_select_stage;
`ifdef DMEM_MUX_SELCHK_EN
  localparam bit SELCHK = 1'b1;
`else
  localparam bit SELCHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic [1:0] in_sel;
  logic [31:0] d4;
  logic [23:0] d3;
  logic ir4, ov4, se4, ir3, ov3, se3;
  logic [7:0] od4, od3;
  int checks = 0, errors = 0;
  logic [7:0] q4[$], q3[$];
  logic [7:0] disp4 = 8'h00, disp3 = 8'h00;
  bit err3 = 1'b0;

  typedef struct {
    bit rst, flush, valid, ready;
    logic [1:0] sel;
    logic [31:0] data;
    bit ev, er;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;
  assign d3 = d4[23:0];

  dmem_wb_select_stage #(.WIDTH(8), .NUM_IN(4)) u4 (
    .clk(clk), .rst(rst), .in_data(d4), .in_sel(in_sel), .in_valid(in_valid), .in_ready(ir4),
    .flush(flush), .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .sel_err(se4));
  dmem_wb_select_stage #(.WIDTH(8), .NUM_IN(3)) u3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_sel(in_sel), .in_valid(in_valid), .in_ready(ir3),
    .flush(flush), .out_data(od3), .out_valid(ov3), .out_ready(out_ready), .sel_err(se3));

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [7:0] src(logic [31:0] d, int k);
    return d[k*8 +: 8];
  endfunction

  // the stage behaves as a FIFO of depth 2 whose head is shown on out_data
  task automatic model_step();
    bit acc, em;
    acc = in_valid && q4.size() < 2;
    em  = q4.size() > 0 && out_ready;
    if (rst) begin
      q4.delete(); q3.delete();
      disp4 = 8'h00; disp3 = 8'h00; err3 = 1'b0;
    end else if (flush) begin
      q4.delete(); q3.delete();
    end else begin
      if (em) begin
        void'(q4.pop_front());
        void'(q3.pop_front());
      end
      if (acc) begin
        q4.push_back(src(d4, int'(in_sel)));
        q3.push_back(in_sel < 3 ? src(d4, int'(in_sel)) : (SELCHK ? 8'h00 : src(d4, 0)));
        if (SELCHK && in_sel == 2'd3) err3 = 1'b1;
      end
    end
    if (q4.size() > 0) disp4 = q4[0];
    if (q3.size() > 0) disp3 = q3[0];
  endtask

  task automatic check_all();
    chk("in_ready4", 32'(ir4), 32'(q4.size() < 2));
    chk("out_valid4", 32'(ov4), 32'(q4.size() > 0));
    chk("out_data4", 32'(od4), 32'(disp4));
    chk("sel_err4", 32'(se4), 0);
    chk("in_ready3", 32'(ir3), 32'(q3.size() < 2));
    chk("out_valid3", 32'(ov3), 32'(q3.size() > 0));
    chk("out_data3", 32'(od3), 32'(disp3));
    chk("sel_err3", 32'(se3), 32'(err3));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(bit r, bit f, bit v, bit rd, logic [1:0] s, logic [31:0] d);
    rst = r; flush = f; in_valid = v; out_ready = rd; in_sel = s; d4 = d;
  endtask

  initial begin
    drive(1, 0, 1, 1, 2'd1, 32'hFFFF_FFFF);
    tbl = '{
      '{1, 0, 1, 1, 2'd1, 32'hFFFF_FFFF, 0, 1, 8'h00},
      '{1, 0, 1, 1, 2'd1, 32'hFFFF_FFFF, 0, 1, 8'h00},
      '{1, 0, 1, 1, 2'd1, 32'hFFFF_FFFF, 0, 1, 8'h00},
      '{0, 0, 0, 1, 2'd0, 32'h0000_0000, 0, 1, 8'h00},
      '{0, 0, 1, 1, 2'd2, 32'h00A5_0000, 1, 1, 8'hA5},
      '{0, 0, 1, 1, 2'd0, 32'h0000_003C, 1, 1, 8'h3C},
      '{0, 0, 0, 1, 2'd0, 32'h0000_0000, 0, 1, 8'h3C},
      '{0, 0, 1, 0, 2'd1, 32'h0000_1100, 1, 1, 8'h11},
      '{0, 0, 1, 0, 2'd3, 32'h2200_0077, 1, 0, 8'h11},
      '{0, 0, 1, 0, 2'd2, 32'h3333_3333, 1, 0, 8'h11},
      '{0, 0, 0, 1, 2'd0, 32'h0000_0000, 1, 1, 8'h22},
      '{0, 0, 0, 1, 2'd0, 32'h0000_0000, 0, 1, 8'h22},
      '{0, 0, 1, 0, 2'd0, 32'h0000_0044, 1, 1, 8'h44},
      '{0, 0, 1, 0, 2'd0, 32'h0000_0055, 1, 0, 8'h44},
      '{0, 1, 1, 1, 2'd0, 32'h0000_0066, 0, 1, 8'h44},
      '{0, 0, 0, 1, 2'd0, 32'h0000_0000, 0, 1, 8'h44}
    };
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].ready, tbl[i].sel, tbl[i].data);
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(ov4), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), 32'(ir4), 32'(tbl[i].er));
      chk($sformatf("vec%0d_data", i), 32'(od4), 32'(tbl[i].ed));
    end
    drive(1, 0, 0, 1, 2'd0, 32'h0);
    cycle();
    drive(0, 0, 1, 1, 2'd3, 32'h00BB_CCDD);
    cycle();
    chk("oor_data3", 32'(od3), SELCHK ? 32'h0 : 32'hDD);
    chk("oor_err3", 32'(se3), 32'(SELCHK));
    drive(0, 0, 1, 1, 2'd1, 32'h00BB_CCDD);
    cycle();
    chk("oor_next_data3", 32'(od3), 32'hCC);
    drive(0, 0, 0, 1, 2'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("oor_err_held", 32'(se3), 32'(SELCHK));
    end
    drive(1, 0, 0, 1, 2'd0, 32'h0);
    cycle();
    chk("oor_err_rst", 32'(se3), 0);
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(49) == 0, $urandom_range(9) == 0, $urandom_range(9) < 7,
            $urandom_range(9) < 6, 2'($urandom_range(3)), $urandom);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
